// File: rtl/ycr_wbs_dmem_sram_pkg.sv
// Shared Wishbone responder definitions: bus width and the responder FSM state encoding.
package ycr_wbs_dmem_sram_pkg;

  localparam int YCR_WB_WIDTH = 32;

  typedef enum logic [1:0] {
    YCR_WBS_ST_IDLE = 2'd0,
    YCR_WBS_ST_CMD  = 2'd1,
    YCR_WBS_ST_WAIT = 2'd2,
    YCR_WBS_ST_ACK  = 2'd3
  } type_ycr_wbs_state_e;

endpackage

// File: rtl/ycr_wbs_dmem_sram.sv
// Wishbone responder driving a single-port data SRAM; one request in flight, registered ack/data.
// Define YCR_WBS_DMEM_ERR_EN to flag addresses beyond the SRAM with err instead of aliasing.
module ycr_wbs_dmem_sram
  import ycr_wbs_dmem_sram_pkg::*;
#(
  parameter int AW         = 9,
  parameter int MEM_RD_LAT = 1
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic                    wbd_stb_i,
  input  logic [YCR_WB_WIDTH-1:0] wbd_adr_i,
  input  logic                    wbd_we_i,
  input  logic [YCR_WB_WIDTH-1:0] wbd_dat_i,
  input  logic [3:0]              wbd_sel_i,
  output logic [YCR_WB_WIDTH-1:0] wbd_dat_o,
  output logic                    wbd_ack_o,
  output logic                    wbd_err_o,
  output logic                    mem_csb0,
  output logic                    mem_web0,
  output logic [3:0]              mem_wmask0,
  output logic [AW-1:0]           mem_addr0,
  output logic [YCR_WB_WIDTH-1:0] mem_din0,
  input  logic [YCR_WB_WIDTH-1:0] mem_dout0
);

  localparam int              LCW      = $clog2(MEM_RD_LAT) + 1;
  localparam logic [LCW-1:0]  LAT_LOAD = LCW'(MEM_RD_LAT - 1);

  type_ycr_wbs_state_e     state, state_d;
  logic [LCW-1:0]          lat_cnt, lat_cnt_d;
  logic                    ack_d, csb_d, web_d;
  logic [YCR_WB_WIDTH-1:0] dat_d, din_d;
  logic [3:0]              wmask_d;
  logic [AW-1:0]           addr_d;
  logic                    req_oor;

`ifdef YCR_WBS_DMEM_ERR_EN
  logic err_q;
  logic unused_adr;

  assign req_oor    = |wbd_adr_i[YCR_WB_WIDTH-1:AW+2];
  assign unused_adr = ^wbd_adr_i[1:0];
  assign wbd_err_o  = err_q;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) err_q <= 1'b0;
    else        err_q <= (state == YCR_WBS_ST_IDLE) && wbd_stb_i && req_oor;
  end
`else
  logic unused_adr;

  assign req_oor    = 1'b0;
  assign unused_adr = ^{wbd_adr_i[YCR_WB_WIDTH-1:AW+2], wbd_adr_i[1:0]};
  assign wbd_err_o  = 1'b0;
`endif

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state      <= YCR_WBS_ST_IDLE;
      lat_cnt    <= '0;
      wbd_ack_o  <= 1'b0;
      wbd_dat_o  <= '0;
      mem_csb0   <= 1'b1;
      mem_web0   <= 1'b1;
      mem_wmask0 <= '0;
      mem_addr0  <= '0;
      mem_din0   <= '0;
    end else begin
      state      <= state_d;
      lat_cnt    <= lat_cnt_d;
      wbd_ack_o  <= ack_d;
      wbd_dat_o  <= dat_d;
      mem_csb0   <= csb_d;
      mem_web0   <= web_d;
      mem_wmask0 <= wmask_d;
      mem_addr0  <= addr_d;
      mem_din0   <= din_d;
    end
  end

  always_comb begin
    state_d   = state;
    lat_cnt_d = lat_cnt;
    ack_d     = 1'b0;
    dat_d     = wbd_dat_o;
    csb_d     = 1'b1;
    web_d     = 1'b1;
    wmask_d   = mem_wmask0;
    addr_d    = mem_addr0;
    din_d     = mem_din0;
    case (state)
      YCR_WBS_ST_IDLE: begin
        if (wbd_stb_i) begin
          if (req_oor) begin
            ack_d   = 1'b1;
            dat_d   = '0;
            state_d = YCR_WBS_ST_ACK;
          end else begin
            addr_d  = wbd_adr_i[AW+1:2];
            din_d   = wbd_dat_i;
            wmask_d = wbd_sel_i;
            csb_d   = 1'b0;
            web_d   = ~wbd_we_i;
            state_d = YCR_WBS_ST_CMD;
          end
        end
      end
      YCR_WBS_ST_CMD: begin
        // Registered web remembers the access type even if stb was dropped early.
        if (!mem_web0) begin
          ack_d   = 1'b1;
          dat_d   = '0;
          state_d = YCR_WBS_ST_ACK;
        end else begin
          lat_cnt_d = LAT_LOAD;
          state_d   = YCR_WBS_ST_WAIT;
        end
      end
      YCR_WBS_ST_WAIT: begin
        if (lat_cnt == '0) begin
          dat_d   = mem_dout0;
          ack_d   = 1'b1;
          state_d = YCR_WBS_ST_ACK;
        end else begin
          lat_cnt_d = lat_cnt - LCW'(1);
        end
      end
      YCR_WBS_ST_ACK: begin
        state_d = YCR_WBS_ST_IDLE;
      end
      default: state_d = YCR_WBS_ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ycr_wbs_dmem_sram.sv
// Bench for ycr_wbs_dmem_sram: two instances (read latency 1 and 3) each with a behavioural SRAM.
module tb_ycr_wbs_dmem_sram;

`ifdef YCR_WBS_DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb [2];
  logic [31:0] adr = '0;
  logic        we  = 1'b0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;

  logic [31:0] dat_o [2];
  logic        ack   [2];
  logic        err   [2];
  logic        csb   [2];
  logic        web   [2];
  logic [3:0]  wmask [2];
  logic [8:0]  maddr [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];

  logic [31:0] rmem [2][512];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ycr_wbs_dmem_sram #(.AW(9), .MEM_RD_LAT(1)) u_dut0 (
    .wb_clk(clk), .wb_rst(rst), .wbd_stb_i(stb[0]), .wbd_adr_i(adr), .wbd_we_i(we),
    .wbd_dat_i(wdat), .wbd_sel_i(sel), .wbd_dat_o(dat_o[0]), .wbd_ack_o(ack[0]),
    .wbd_err_o(err[0]), .mem_csb0(csb[0]), .mem_web0(web[0]), .mem_wmask0(wmask[0]),
    .mem_addr0(maddr[0]), .mem_din0(din[0]), .mem_dout0(dout[0])
  );

  ycr_wbs_dmem_sram #(.AW(9), .MEM_RD_LAT(3)) u_dut1 (
    .wb_clk(clk), .wb_rst(rst), .wbd_stb_i(stb[1]), .wbd_adr_i(adr), .wbd_we_i(we),
    .wbd_dat_i(wdat), .wbd_sel_i(sel), .wbd_dat_o(dat_o[1]), .wbd_ack_o(ack[1]),
    .wbd_err_o(err[1]), .mem_csb0(csb[1]), .mem_web0(web[1]), .mem_wmask0(wmask[1]),
    .mem_addr0(maddr[1]), .mem_din0(din[1]), .mem_dout0(dout[1])
  );

  // SRAM model: command sampled on an edge, read word appears after LAT edges.
  for (genvar g = 0; g < 2; g++) begin : g_sram
    logic [31:0] mem  [512] = '{default: 32'h0};
    logic [31:0] pipe [3]   = '{default: 32'hBAD0_BAD0};
    always @(posedge clk) begin
      if (!csb[g] && !web[g])
        for (int b = 0; b < 4; b++)
          if (wmask[g][b]) mem[maddr[g]][8*b +: 8] <= din[g][8*b +: 8];
      pipe[0] <= (!csb[g] && web[g]) ? mem[maddr[g]] : 32'hBAD0_BAD0;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign dout[g] = (g == 0) ? pipe[0] : pipe[2];
  end

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on DUT d, checked against the reference memory; keep leaves stb high after ack.
  task automatic xfer(int d, logic [31:0] a, logic w, logic [31:0] wd, logic [3:0] s,
                      bit keep, output logic [31:0] rd);
    bit         oor;
    logic [8:0] idx;
    int         exp_lat, cyc, csb_low;
    logic [31:0] exp_dat;
    bit         got;
    oor     = ERR_EN && (a[31:11] != 21'h0);
    idx     = a[10:2];
    exp_lat = oor ? 1 : (w ? 2 : 2 + lat_of(d));
    exp_dat = (oor || w) ? 32'h0 : rmem[d][idx];
    stb[d] = 1'b1; adr = a; we = w; wdat = wd; sel = s;
    cyc = 0; csb_low = 0; got = 1'b0;
    while (!got && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 && !oor) begin
        chk("cmd_csb", 32'(csb[d]), 32'h0);
        chk("cmd_web", 32'(web[d]), 32'(!w));
        chk("cmd_addr", 32'(maddr[d]), 32'(idx));
        chk("cmd_wmask", 32'(wmask[d]), 32'(s));
        if (w) chk("cmd_din", din[d], wd);
      end
      if (!csb[d]) csb_low++;
      if (ack[d]) got = 1'b1;
    end
    chk("ack_seen", 32'(got), 32'h1);
    chk("ack_latency", 32'(cyc), 32'(exp_lat));
    chk("ack_err", 32'(err[d]), 32'(oor));
    chk("ack_dat", dat_o[d], exp_dat);
    chk("csb_pulses", 32'(csb_low), oor ? 32'h0 : 32'h1);
    rd = dat_o[d];
    if (!keep) stb[d] = 1'b0;
    @(posedge clk); #1;
    chk("ack_single", 32'(ack[d]), 32'h0);
    if (w && !oor)
      for (int b = 0; b < 4; b++)
        if (s[b]) rmem[d][idx][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int nacks;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 512; i++) rmem[d][i] = 32'h0;

    // Reset held with stb asserted.
    stb[0] = 1'b1; stb[1] = 1'b1; adr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_ack", 32'(ack[d]), 32'h0);
        chk("rst_csb", 32'(csb[d]), 32'h1);
        chk("rst_dat", dat_o[d], 32'h0);
      end
    end
    chk("rst_err", 32'(err[0]), 32'h0);
    chk("rst_web", 32'(web[0]), 32'h1);
    chk("rst_wmask", 32'(wmask[0]), 32'h0);
    chk("rst_addr", 32'(maddr[0]), 32'h0);
    chk("rst_din", din[0], 32'h0);
    stb[0] = 1'b0; stb[1] = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Full write, byte-lane write, read-back of merged word.
    xfer(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, rd);
    xfer(0, 32'h10, 1'b1, 32'h00AA0000, 4'b0100, 1'b0, rd);
    xfer(0, 32'h10, 1'b0, 32'h0, 4'hF, 1'b0, rd);
    chk("merged_word", rd, 32'hDEAABEEF);
    xfer(0, 32'h14, 1'b1, 32'h12345678, 4'h0, 1'b0, rd);
    xfer(0, 32'h14, 1'b0, 32'h0, 4'hF, 1'b0, rd);
    chk("sel0_nochange", rd, 32'h0);

    // Latency-3 instance at the top word, then stb held across the ack.
    xfer(1, 32'h7FC, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0, rd);
    xfer(1, 32'h7FC, 1'b0, 32'h0, 4'hF, 1'b1, rd);
    chk("lat3_word", rd, 32'hCAFEF00D);
    xfer(1, 32'h7FC, 1'b0, 32'h0, 4'hF, 1'b0, rd);

    // Beyond-range address: err with macro, alias to word 0 without.
    xfer(0, 32'h0000_0800, 1'b0, 32'h0, 4'hF, 1'b0, rd);
    xfer(0, 32'h0000_0800, 1'b1, 32'h5A5A5A5A, 4'hF, 1'b0, rd);

    // Reset during WAIT (latency-3) and during CMD (latency-1, csb low).
    stb[1] = 1'b1; adr = 32'h40; we = 1'b0; sel = 4'hF;
    @(posedge clk); #1;
    stb[0] = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_csb", 32'(csb[0]), 32'h0);
    rst = 1'b1;
    #1;
    chk("async_rst_csb0", 32'(csb[0]), 32'h1);
    chk("async_rst_csb1", 32'(csb[1]), 32'h1);
    stb[0] = 1'b0; stb[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    nacks = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      nacks += int'(ack[0]) + int'(ack[1]);
    end
    chk("no_ack_after_rst", 32'(nacks), 32'h0);
    xfer(1, 32'h40, 1'b0, 32'h0, 4'hF, 1'b0, rd);
    xfer(0, 32'h40, 1'b1, 32'h0BADCAFE, 4'b1010, 1'b0, rd);

    // Randomized traffic on both instances.
    for (int i = 0; i < 80; i++) begin
      int          d;
      logic [31:0] a;
      d = int'($urandom_range(1, 0));
      a = {21'h0, 11'($urandom_range(2047, 0))};
      if ($urandom_range(7, 0) == 0) a[31:11] = 21'($urandom_range(32'h1FFFFF, 1));
      xfer(d, a, 1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 0)), 1'b0, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
